// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd_arbiter slice.
//   state_t        : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   DEFAULT_WIDTH  : operand/result width of the gcd engine
//   timer_w()      : width of the watchdog counter for a given TIMEOUT
package gcd_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // The watchdog counts 0 .. TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
    function automatic int timer_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/gcd_arbiter_rr.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index for this decision
//   gnt_o : one-hot grant (first set bit scanning upward from ptr_i, wrapping)
//   idx_o : binary index of the granted requester
//   any_o : at least one request is set
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one gcd engine between NUM_REQ requesters, serving one request at a
// time in round-robin order. Zero operands are answered locally; a watchdog
// aborts (and resets) an engine that never signals done.
//   clk, rst               : clock, synchronous active-high reset
//   req/req_a/req_b        : per-requester request level and packed operands
//   ack                    : one-hot pulse, operands of that requester latched
//   rsp_valid/rsp_data/err : one-hot result pulse, data, timeout flag
//   eng_rst/eng_go         : engine reset (rst or abort) and start pulse
//   eng_in1/eng_in2        : latched operands, stable while the engine runs
//   eng_out/eng_done       : engine result and completion (rising edge used)
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     eng_rst,
    output logic                     eng_go,
    output logic [WIDTH-1:0]         eng_in1,
    output logic [WIDTH-1:0]         eng_in2,
    input  logic [WIDTH-1:0]         eng_out,
    input  logic                     eng_done
);

    localparam int                 PTR_W      = $clog2(NUM_REQ);
    localparam int                 TIMER_W    = timer_w(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   in1_q, in1_d;
    logic [WIDTH-1:0]   in2_q, in2_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic               bypass_q, bypass_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               done_q;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [WIDTH-1:0]   win_a, win_b;
    logic [NUM_REQ-1:0] owner_oh;
    logic               done_edge;
    logic               abort;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // AND-OR mux on the one-hot grant picks the winner's operands.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_a = win_a | req_a[i*WIDTH +: WIDTH];
                win_b = win_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // done_q follows eng_done every cycle, so a level left high by the
    // previous operation never looks like a fresh completion.
    assign done_edge = eng_done & ~done_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        data_d   = data_q;
        err_d    = err_q;
        bypass_d = bypass_q;
        timer_d  = timer_q;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    owner_d = gnt_idx;
                    in1_d   = win_a;
                    in2_d   = win_b;
                    err_d   = 1'b0;
                    if (win_a == '0 || win_b == '0) begin
                        // gcd(x,0) = x and gcd(0,0) = 0, both equal a|b.
                        data_d   = win_a | win_b;
                        bypass_d = 1'b1;
                        state_d  = RESP;
                    end else begin
                        bypass_d = 1'b0;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion seen in the timeout cycle still counts as normal.
                if (done_edge) begin
                    data_d  = eng_out;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    abort   = 1'b1;
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RESP: begin
                ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all of them update from the same pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            bypass_q <= 1'b0;
            timer_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            data_q   <= data_d;
            err_q    <= err_d;
            bypass_q <= bypass_d;
            timer_q  <= timer_d;
            done_q   <= eng_done;
        end
    end

    assign owner_oh  = NUM_REQ'(1) << owner_q;
    // Engine path acks in ISSUE; the bypass path acks together with the response.
    assign ack       = ((state_q == ISSUE) || (state_q == RESP && bypass_q)) ? owner_oh : '0;
    assign rsp_valid = (state_q == RESP) ? owner_oh : '0;
    assign rsp_data  = (state_q == RESP) ? data_q : '0;
    assign rsp_err   = (state_q == RESP) & err_q;
    assign eng_go    = (state_q == ISSUE);
    assign eng_in1   = in1_q;
    assign eng_in2   = in2_q;
    assign eng_rst   = rst | abort;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: directed jobs with hand-computed results,
// an engine stub with configurable latency / hang / sticky-done behaviour.
module tb_gcd_arbiter;
    import gcd_pkg::*;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic         err;
        logic         byp;
    } job_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_a = '0;
    logic [NR*W-1:0] req_b = '0;
    logic [NR-1:0]   ack, rsp_valid;
    logic [W-1:0]    rsp_data;
    logic            rsp_err, eng_rst, eng_go;
    logic [W-1:0]    eng_in1, eng_in2;
    logic [W-1:0]    eng_out  = '0;
    logic            eng_done = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    job_t sb[$];
    job_t pend[$];

    gcd_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .eng_rst   (eng_rst),
        .eng_go    (eng_go),
        .eng_in1   (eng_in1),
        .eng_in2   (eng_in2),
        .eng_out   (eng_out),
        .eng_done  (eng_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        return NR'(1) << i;
    endfunction

    function automatic job_t mk(input int idx, input int a, input int b, input int exp,
                                input bit err, input bit byp);
        job_t j;
        j.idx = 2'(idx);
        j.a   = W'(a);
        j.b   = W'(b);
        j.exp = W'(exp);
        j.err = err;
        j.byp = byp;
        return j;
    endfunction

    // ---------------- engine stub ----------------
    int           eng_lat    = 5;
    bit           eng_hang   = 1'b0;
    bit           eng_sticky = 1'b0;
    bit           eng_busy   = 1'b0;
    int           eng_cnt    = 0;
    logic [W-1:0] eng_op_a   = '0;
    logic [W-1:0] eng_op_b   = '0;

    function automatic logic [W-1:0] euclid(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (eng_rst) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
            eng_done <= 1'b0;
            eng_out  <= '0;
        end else if (eng_go) begin
            eng_busy <= !eng_hang;
            eng_cnt  <= eng_lat;
            eng_op_a <= eng_in1;
            eng_op_b <= eng_in2;
            if (!eng_sticky) eng_done <= 1'b0;
        end else if (eng_busy) begin
            if (eng_cnt == 2) eng_done <= 1'b0;
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                eng_out  <= euclid(eng_op_a, eng_op_b);
                eng_busy <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // ---------------- requester agents ----------------
    // Each requester presents its oldest pending job and drops it in the ack cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (ack[i] === 1'b1) begin
                for (int k = 0; k < pend.size(); k++) begin
                    if (pend[k].idx == 2'(i)) begin
                        pend.delete(k);
                        break;
                    end
                end
            end
        end
        req   = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < pend.size(); k++) begin
                if (pend[k].idx == 2'(i)) begin
                    req[i]           = 1'b1;
                    req_a[i*W +: W]  = pend[k].a;
                    req_b[i*W +: W]  = pend[k].b;
                    break;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int   cyc       = 0;
    int   go_cnt    = 0;
    int   abort_cnt = 0;
    int   go_cyc    = 0;
    int   abort_cyc = 0;
    bit   in_stable = 1'b1;

    always @(negedge clk) begin
        job_t h;
        cyc++;
        if (rst) begin
            go_cnt    = 0;
            abort_cnt = 0;
            in_stable = 1'b1;
        end else begin
            if (eng_go) begin
                go_cnt++;
                go_cyc = cyc;
                if (sb.size() > 0) begin
                    check("issue_ack", ack, oh(sb[0].idx));
                    check("issue_in1", eng_in1, sb[0].a);
                    check("issue_in2", eng_in2, sb[0].b);
                end
            end
            if (eng_rst) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            if (rsp_valid == '0) begin
                if (go_cnt > 0 && sb.size() > 0 &&
                    (eng_in1 !== sb[0].a || eng_in2 !== sb[0].b))
                    in_stable = 1'b0;
            end else if (sb.size() == 0) begin
                check("spurious_rsp", rsp_valid, '0);
            end else begin
                h = sb.pop_front();
                check("rsp_owner", rsp_valid, oh(h.idx));
                check("rsp_data", rsp_data, h.exp);
                check("rsp_err", rsp_err, h.err);
                check("go_pulses", go_cnt, h.byp ? 0 : 1);
                check("abort_pulses", abort_cnt, h.err ? 1 : 0);
                if (h.err) check("abort_delay", abort_cyc - go_cyc, TO);
                if (h.byp) begin
                    check("bypass_ack", ack, oh(h.idx));
                end else begin
                    check("resp_ack", ack, '0);
                    check("in_stable", in_stable, 1'b1);
                end
                go_cnt    = 0;
                abort_cnt = 0;
                in_stable = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input job_t j);
        sb.push_back(j);
        pend.push_back(j);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || pend.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check({name, "_drain"}, sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ack"}, ack, '0);
        check({name, "_rsp_valid"}, rsp_valid, '0);
        check({name, "_rsp_data"}, rsp_data, '0);
        check({name, "_rsp_err"}, rsp_err, 1'b0);
        check({name, "_eng_go"}, eng_go, 1'b0);
        check({name, "_eng_in1"}, eng_in1, '0);
        check({name, "_eng_in2"}, eng_in2, '0);
        check({name, "_eng_rst"}, eng_rst, 1'b1);
        check({name, "_state"}, 64'(dut.state_q), 64'(IDLE));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        do_reset();

        // single engine request
        issue(mk(1, 48, 18, 6, 0, 0));
        wait_drain("single");

        // zero-operand bypass
        issue(mk(2, 0, 35, 35, 0, 1));
        wait_drain("bypass35");
        issue(mk(2, 0, 0, 0, 0, 1));
        wait_drain("bypass0");

        // hung engine -> timeout, then a normal completion
        eng_hang = 1'b1;
        issue(mk(3, 15, 10, 0, 1, 0));
        wait_drain("timeout");
        eng_hang = 1'b0;
        issue(mk(3, 15, 10, 5, 0, 0));
        wait_drain("after_timeout");

        // done edge in the very cycle the watchdog would fire
        eng_lat = 15;
        issue(mk(3, 44, 33, 11, 0, 0));
        wait_drain("done_at_limit");
        eng_lat = 5;

        // reset while waiting on the engine abandons the request
        pend.push_back(mk(1, 40, 25, 5, 0, 0));
        n = 0;
        while (eng_go !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rst_wait_go", eng_go, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // done left high by the previous op must not finish the next one early
        issue(mk(1, 40, 25, 5, 0, 0));
        wait_drain("prime_done");
        eng_sticky = 1'b1;
        issue(mk(1, 27, 18, 9, 0, 0));
        wait_drain("sticky_done");
        eng_sticky = 1'b0;

        // all four requesting: round-robin 0,1,2,3,0 from a fresh pointer
        do_reset();
        issue(mk(0, 12, 8, 4, 0, 0));
        issue(mk(1, 9, 6, 3, 0, 0));
        issue(mk(2, 10, 4, 2, 0, 0));
        issue(mk(3, 21, 14, 7, 0, 0));
        issue(mk(0, 12, 8, 4, 0, 0));
        wait_drain("rr_all");

        // pointer wrap: after requester 2, req=0101 serves 0 then 2
        issue(mk(2, 36, 24, 12, 0, 0));
        wait_drain("wrap_pre");
        issue(mk(0, 17, 5, 1, 0, 0));
        issue(mk(2, 0, 9, 9, 0, 1));
        wait_drain("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
